// File: rtl/coax_frame_buffer_rx.sv
// Coax receive frame buffer: one-word staging register feeding a first-word fall-through FIFO.
// Optional parity checking of received words is enabled by defining COAX_RX_PARITY_CHECK_EN.
module coax_frame_buffer_rx #(
  parameter int DEPTH             = 8,
  parameter int ALMOST_FULL_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_active,
  input  logic [9:0]               rx_data,
  input  logic                     rx_parity,
  input  logic                     rx_data_strobe,
  input  logic                     rx_error_strobe,
  input  logic [9:0]               rx_error_code,
  input  logic                     read_strobe,
  input  logic                     error_clear,
  output logic [11:0]              data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     error,
  output logic [9:0]               error_code
);

  localparam int            AW             = $clog2(DEPTH);
  localparam logic [AW:0]   AF_LEVEL       = (AW+1)'(ALMOST_FULL_LEVEL);
  localparam logic [9:0]    ERROR_OVERFLOW = 10'h100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    ERROR     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        stage_vld_q, stage_vld_d;
  logic [10:0] stage_q, stage_d;
  logic [9:0]  code_q, code_d;
  logic        act_prev_q;
  logic [11:0] mem_q [DEPTH];

  logic        rise_s;
  logic        pok_s;
  logic        push_req_s;
  logic        push_eof_s;
  logic        do_push_s;
  logic        do_pop_s;
  logic        overflow_s;
  logic        empty_s;
  logic        full_s;
  logic [AW:0] level_s;

`ifdef COAX_RX_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [9:0] word, input logic par);
    return ^{word, par};
  endfunction

  assign pok_s = odd_parity_ok(rx_data, rx_parity);
`else
  assign pok_s = 1'b1;
`endif

  // Prev starts high so a frame already running at reset release is never seen as a rise.
  assign rise_s  = rx_active && !act_prev_q;
  assign level_s = wr_ptr_q - rd_ptr_q;
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    state_d     = state_q;
    stage_vld_d = stage_vld_q;
    stage_d     = stage_q;
    code_d      = code_q;
    push_req_s  = 1'b0;
    push_eof_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d     = RECEIVING;
          stage_vld_d = rx_data_strobe;
          stage_d     = {pok_s, rx_data};
        end else begin
          state_d     = IDLE;
        end
      end
      RECEIVING: begin
        if (!rx_active) begin
          push_req_s  = stage_vld_q;
          push_eof_s  = 1'b1;
          stage_vld_d = 1'b0;
          state_d     = IDLE;
        end else if (rx_data_strobe) begin
          push_req_s  = stage_vld_q;
          stage_vld_d = 1'b1;
          stage_d     = {pok_s, rx_data};
        end else begin
          state_d     = RECEIVING;
        end
      end
      ERROR: begin
        stage_vld_d = 1'b0;
        if (error_clear) begin
          state_d = IDLE;
          code_d  = 10'h000;
        end else begin
          state_d = ERROR;
        end
      end
      default: begin
        state_d     = IDLE;
        stage_vld_d = 1'b0;
      end
    endcase

    // A receiver error in the same cycle suppresses the push and owns the error code.
    if (rx_error_strobe) begin
      push_req_s = 1'b0;
    end else begin
      push_req_s = push_req_s;
    end
    do_pop_s   = read_strobe && !empty_s;
    do_push_s  = push_req_s && (!full_s || do_pop_s);
    overflow_s = push_req_s && full_s && !do_pop_s;

    if (rx_error_strobe || overflow_s) begin
      state_d     = ERROR;
      stage_vld_d = 1'b0;
      if (state_q != ERROR) begin
        code_d = rx_error_strobe ? rx_error_code : ERROR_OVERFLOW;
      end else begin
        code_d = code_q;
      end
    end else begin
      code_d = code_d;
    end

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push_s};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop_s};
  end

  // Control state, pointers, staging and error latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stage_vld_q <= 1'b0;
      stage_q     <= 11'h000;
      code_q      <= 10'h000;
      act_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      code_q      <= code_d;
      act_prev_q  <= rx_active;
    end
  end

  // Storage array, entries are {eof, parity_ok, word}.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {push_eof_s, stage_q};
    end
  end

  assign data        = mem_q[rd_ptr_q[AW-1:0]];
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (level_s >= AF_LEVEL);
  assign level       = level_s;
  assign error       = (state_q == ERROR);
  assign error_code  = code_q;

endmodule

// File: tb/tb_coax_frame_buffer_rx.sv
// Scoreboard bench for coax_frame_buffer_rx: stimulus queues expected entries, a monitor checks every pop.
module tb_coax_frame_buffer_rx;

`ifdef COAX_RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        rx_active;
  logic [9:0]  rx_data;
  logic        rx_parity;
  logic        rx_data_strobe;
  logic        rx_error_strobe;
  logic [9:0]  rx_error_code;
  logic        read_strobe;
  logic        error_clear;
  logic [11:0] data;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic [3:0]  level;
  logic        error;
  logic [9:0]  error_code;

  int          checks;
  int          failures;
  logic [11:0] exp_q [$];

  coax_frame_buffer_rx #(.DEPTH(8), .ALMOST_FULL_LEVEL(6)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_active       (rx_active),
    .rx_data         (rx_data),
    .rx_parity       (rx_parity),
    .rx_data_strobe  (rx_data_strobe),
    .rx_error_strobe (rx_error_strobe),
    .rx_error_code   (rx_error_code),
    .read_strobe     (read_strobe),
    .error_clear     (error_clear),
    .data            (data),
    .empty           (empty),
    .full            (full),
    .almost_full     (almost_full),
    .level           (level),
    .error           (error),
    .error_code      (error_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted pop is compared with the head of the scoreboard.
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset_n && read_strobe && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected actual=%h required=no_entry", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL read_data actual=%h required=%h", data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic strobe_word(input logic [9:0] w, input logic p);
    rx_data        = w;
    rx_parity      = p;
    rx_data_strobe = 1'b1;
    tick();
    rx_data_strobe = 1'b0;
    tick();
  endtask

  // Sends n words base, base+step, ...; the first 'keep' words are expected in the FIFO.
  task automatic send_frame(input logic [9:0] base, input logic [9:0] step, input int n, input int keep);
    logic [9:0] w;
    rx_active = 1'b1;
    tick();
    w = base;
    for (int i = 0; i < n; i++) begin
      strobe_word(w, ~(^w));
      if (i < keep) exp_q.push_back({(i == n - 1), 1'b1, w});
      w = w + step;
    end
    rx_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_n(input int n);
    read_strobe = 1'b1;
    repeat (n) tick();
    read_strobe = 1'b0;
  endtask

  task automatic pulse_clear();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    rx_active = 1'b0;
    rx_data = 10'h000;
    rx_parity = 1'b0;
    rx_data_strobe = 1'b0;
    rx_error_strobe = 1'b0;
    rx_error_code = 10'h000;
    read_strobe = 1'b0;
    error_clear = 1'b0;
    repeat (2) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    tick();

    // Eight-word frame fills the FIFO exactly; last entry carries eof.
    send_frame(10'h001, 10'h001, 8, 8);
    check("f8_full", 32'(full), 32'd1);
    check("f8_level", 32'(level), 32'd8);
    check("f8_almost_full", 32'(almost_full), 32'd1);
    check("f8_error", 32'(error), 32'd0);
    read_n(8);
    check("f8_empty", 32'(empty), 32'd1);
    check("f8_af_after", 32'(almost_full), 32'd0);

    // Nine-word frame overflows on the eof push.
    send_frame(10'h000, 10'h000, 9, 8);
    check("f9_full", 32'(full), 32'd1);
    check("f9_level", 32'(level), 32'd8);
    check("f9_error", 32'(error), 32'd1);
    check("f9_code", 32'(error_code), 32'h100);
    pulse_clear();
    tick();
    check("f9_cleared", 32'(error), 32'd0);
    read_n(8);
    check("f9_empty", 32'(empty), 32'd1);

    // 4 + 4 + 1 frames: ninth push overflows, then read+clear and a new 1-word frame fits.
    send_frame(10'h011, 10'h001, 4, 4);
    send_frame(10'h021, 10'h001, 4, 4);
    send_frame(10'h031, 10'h001, 1, 0);
    check("f441_error", 32'(error), 32'd1);
    check("f441_code", 32'(error_code), 32'h100);
    check("f441_level", 32'(level), 32'd8);
    read_strobe = 1'b1;
    error_clear = 1'b1;
    tick();
    read_strobe = 1'b0;
    error_clear = 1'b0;
    tick();
    check("f441_clear", 32'(error), 32'd0);
    check("f441_level7", 32'(level), 32'd7);
    send_frame(10'h041, 10'h001, 1, 1);
    check("f441_refill", 32'(level), 32'd8);
    check("f441_noerr", 32'(error), 32'd0);
    read_n(8);
    check("f441_empty", 32'(empty), 32'd1);

    // Receiver error mid-frame: staged and later words discarded, first code held.
    rx_active = 1'b1;
    tick();
    strobe_word(10'h051, ~(^10'h051));
    strobe_word(10'h052, ~(^10'h052));
    strobe_word(10'h053, ~(^10'h053));
    exp_q.push_back({1'b0, 1'b1, 10'h051});
    exp_q.push_back({1'b0, 1'b1, 10'h052});
    rx_error_strobe = 1'b1;
    rx_error_code = 10'h002;
    tick();
    rx_error_strobe = 1'b0;
    strobe_word(10'h054, ~(^10'h054));
    strobe_word(10'h055, ~(^10'h055));
    rx_error_strobe = 1'b1;
    rx_error_code = 10'h3ff;
    tick();
    rx_error_strobe = 1'b0;
    rx_active = 1'b0;
    tick();
    tick();
    check("rxerr_error", 32'(error), 32'd1);
    check("rxerr_code", 32'(error_code), 32'h002);
    check("rxerr_level", 32'(level), 32'd2);
    read_n(2);
    check("rxerr_empty", 32'(empty), 32'd1);
    pulse_clear();
    tick();
    check("rxerr_cleared", 32'(error), 32'd0);
    send_frame(10'h061, 10'h001, 1, 1);
    check("rxerr_idle_frame", 32'(level), 32'd1);
    read_n(1);

    // Parity word 10'h001 with parity bit 1 has an even ones count.
    rx_active = 1'b1;
    tick();
    strobe_word(10'h001, 1'b1);
    rx_active = 1'b0;
    tick();
    tick();
    exp_q.push_back({1'b1, (PCHK ? 1'b0 : 1'b1), 10'h001});
    check("par_level", 32'(level), 32'd1);
    check("par_error", 32'(error), 32'd0);
    read_n(1);

    // Asynchronous reset mid-frame with three entries stored and an error latched.
    rx_active = 1'b1;
    tick();
    strobe_word(10'h071, ~(^10'h071));
    strobe_word(10'h072, ~(^10'h072));
    strobe_word(10'h073, ~(^10'h073));
    strobe_word(10'h074, ~(^10'h074));
    check("ar_level3", 32'(level), 32'd3);
    rx_error_strobe = 1'b1;
    rx_error_code = 10'h005;
    tick();
    rx_error_strobe = 1'b0;
    check("ar_error_set", 32'(error), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_level", 32'(level), 32'd0);
    check("ar_full", 32'(full), 32'd0);
    check("ar_af", 32'(almost_full), 32'd0);
    check("ar_error", 32'(error), 32'd0);
    check("ar_code", 32'(error_code), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    strobe_word(10'h081, ~(^10'h081));
    strobe_word(10'h082, ~(^10'h082));
    rx_active = 1'b0;
    tick();
    tick();
    check("ar_ignored_frame", 32'(level), 32'd0);
    send_frame(10'h091, 10'h001, 2, 2);
    check("ar_new_frame", 32'(level), 32'd2);
    read_n(2);
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coax_frame_buffer_rx.md
COAX_FRAME_BUFFER_RX -- requirements
Module: coax_frame_buffer_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ALMOST_FULL_LEVEL, default 6, meaning the occupancy at which almost_full asserts (1..DEPTH).
REQ-003 SHALL have ports, one per line:
  clk  in  1  clock, all logic on rising edge
  reset_n  in  1  reset, asynchronous and active-low
  rx_active  in  1  word receiver inside a frame
  rx_data  in  10  received word
  rx_parity  in  1  received parity bit
  rx_data_strobe  in  1  one-cycle pulse, rx_data/rx_parity valid
  rx_error_strobe  in  1  one-cycle pulse, receiver error
  rx_error_code  in  10  receiver error code, valid with rx_error_strobe
  read_strobe  in  1  pop head entry
  error_clear  in  1  clear latched error
  data  out  12  head entry {eof, parity_ok, word[9:0]}
  empty  out  1  FIFO empty
  full  out  1  FIFO full
  almost_full  out  1  level >= ALMOST_FULL_LEVEL
  level  out  clog2(DEPTH)+1  entries stored
  error  out  1  error latched
  error_code  out  10  latched error code

Function
REQ-004 SHALL hold each received word in a one-entry staging register before it is pushed; eof is decided at push time.
REQ-005 SHALL push the staged word with eof=0 in the cycle after the next rx_data_strobe; the new word enters staging in that cycle.
REQ-006 SHALL push the staged word with eof=1 in the cycle after rx_active falls; a frame with zero words pushes nothing.
REQ-007 SHALL use states IDLE (rx_active low), RECEIVING (rx_active high), ERROR; IDLE->RECEIVING on rx_active rise, RECEIVING->IDLE after the eof push, any->ERROR on an error event.
REQ-008 SHALL present the head entry on data combinationally (first-word fall-through); data is don't-care when empty.
REQ-009 SHALL pop on read_strobe when not empty, with data, level, empty and full updated next cycle; read_strobe when empty SHALL be ignored.
REQ-010 SHALL accept push and pop in the same cycle, including when full, leaving level unchanged.
REQ-011 SHALL treat a push when full without a simultaneous pop as overflow: word discarded, FIFO contents unchanged, error_code=10'h100 (ERROR_OVERFLOW).
REQ-012 SHALL latch rx_error_code on rx_error_strobe as an error event; receiver code SHALL take priority over overflow in the same cycle.
REQ-013 SHALL, in ERROR, discard staging and all further words until error_clear, then go to IDLE; FIFO reads SHALL continue normally in ERROR.
REQ-014 SHALL hold the first error code; later errors while in ERROR SHALL NOT overwrite it.
REQ-015 SHALL wrap read/write pointers modulo DEPTH, with full/empty from an extra pointer bit.

Reset
REQ-016 SHALL, while reset_n low, asynchronously force: pointers 0, staging empty, state IDLE, empty=1, full=0, almost_full=0, level=0, error=0, error_code=0.
REQ-017 SHALL discard a partial frame on reset mid-frame; after release, a frame already in progress (rx_active high) SHALL be ignored until rx_active falls.

Configuration
REQ-018 SHALL, with COAX_RX_PARITY_CHECK_EN defined, set parity_ok=1 only when the ones count of {rx_data, rx_parity} is odd; a failing word is still stored with parity_ok=0 and raises no error.
REQ-019 SHALL, without COAX_RX_PARITY_CHECK_EN, store parity_ok=1 for every word and contain no parity logic.

Verification
REQ-020 SHALL verify: frame of 8 words 10'h001..10'h008 with correct parity, DEPTH=8 -> full=1, level=8, error=0, entry 8 eof=1; 8 reads -> words in order, empty=1.
REQ-021 SHALL verify: frame of 9 words 10'h000 parity 1, DEPTH=8 -> full=1, error=1, error_code=10'h100, stored words 1-8 all eof=0.
REQ-022 SHALL verify: 4-word frame, 4-word frame, 1-word frame, DEPTH=8 -> overflow error on the 9th push; a read plus error_clear then a 1-word frame -> accepted with eof=1.
REQ-023 SHALL verify: rx_error_strobe with code 10'h002 mid-frame -> error_code=10'h002, later words discarded, earlier entries still readable; error_clear -> IDLE.
REQ-024 SHALL verify: word 10'h001 with parity 1 -> parity_ok=0 with COAX_RX_PARITY_CHECK_EN, parity_ok=1 without.
REQ-025 SHALL verify: reset_n low mid-frame with 3 entries stored -> all outputs at reset values immediately, no clk edge required.
